// File: rtl/truth_table_sweep_if.sv
// truth_table_sweep_if -- handshake and data bundle for truth_table_sweep.
//
// Parameter N_IN: number of Boolean inputs swept; DEPTH = 2**N_IN rows.
// Signals:
//   start, abort, func_tt[DEPTH], out_ready   -> requester to sweeper
//   busy, out_valid, out_vec[N_IN], out_bit,
//   ones_cnt[N_IN+1], done                    -> sweeper to requester
// Macro SWEEP_CMP_EN adds exp_tt[DEPTH] (to sweeper) and mismatch,
// mismatch_cnt[N_IN+1] (from sweeper).
// Modports: master = requester / stream sink, slave = the sweeper.
interface truth_table_sweep_if #(
    parameter int N_IN = 3
);
    localparam int DEPTH = 2 ** N_IN;

    logic              start;
    logic              abort;
    logic [DEPTH-1:0]  func_tt;
    logic              out_ready;
    logic              busy;
    logic              out_valid;
    logic [N_IN-1:0]   out_vec;
    logic              out_bit;
    logic [N_IN:0]     ones_cnt;
    logic              done;
`ifdef SWEEP_CMP_EN
    logic [DEPTH-1:0]  exp_tt;
    logic              mismatch;
    logic [N_IN:0]     mismatch_cnt;
`endif

    modport master (
        output start, abort, func_tt, out_ready,
`ifdef SWEEP_CMP_EN
        output exp_tt,
        input  mismatch, mismatch_cnt,
`endif
        input  busy, out_valid, out_vec, out_bit, ones_cnt, done
    );

    modport slave (
        input  start, abort, func_tt, out_ready,
`ifdef SWEEP_CMP_EN
        input  exp_tt,
        output mismatch, mismatch_cnt,
`endif
        output busy, out_valid, out_vec, out_bit, ones_cnt, done
    );
endinterface

// File: rtl/truth_table_sweep.sv
// truth_table_sweep -- streams every row of a captured N_IN-input truth
// table over a valid/ready handshake and counts the rows whose output is 1.
//
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : truth_table_sweep_if.slave (start/abort/func_tt/out_ready in,
//            busy/out_valid/out_vec/out_bit/ones_cnt/done out)
// Optional feature: define SWEEP_CMP_EN to capture an expected table
// exp_tt alongside func_tt and flag/count rows where the two differ.
module truth_table_sweep #(
    parameter int N_IN = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    truth_table_sweep_if.slave  bus
);
    localparam int DEPTH = 2 ** N_IN;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [DEPTH-1:0]  tt_q;
    logic [N_IN-1:0]   idx;
    logic [N_IN-1:0]   idx_nxt;
    logic              busy_q;
    logic              valid_q;
    logic              bit_q;
    logic [N_IN:0]     ones_q;
    logic              done_q;
`ifdef SWEEP_CMP_EN
    logic [DEPTH-1:0]  exp_q;
    logic              mis_q;
    logic [N_IN:0]     mis_cnt_q;
`endif

    assign idx_nxt = idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tt_q      <= '0;
            idx       <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            bit_q     <= 1'b0;
            ones_q    <= '0;
            done_q    <= 1'b0;
`ifdef SWEEP_CMP_EN
            exp_q     <= '0;
            mis_q     <= 1'b0;
            mis_cnt_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        tt_q    <= bus.func_tt;
                        idx     <= '0;
                        ones_q  <= '0;
                        // Row 0 is presented straight from the incoming table
                        // so out_bit is valid on the first RUN cycle.
                        bit_q   <= bus.func_tt[0];
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= RUN;
`ifdef SWEEP_CMP_EN
                        exp_q     <= bus.exp_tt;
                        mis_q     <= bus.func_tt[0] ^ bus.exp_tt[0];
                        mis_cnt_q <= '0;
`endif
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        // Abort wins over a simultaneous transfer: nothing counted.
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
`ifdef SWEEP_CMP_EN
                        mis_q   <= 1'b0;
`endif
                    end else if (bus.out_ready) begin
                        ones_q <= ones_q + (N_IN+1)'(bit_q);
`ifdef SWEEP_CMP_EN
                        if (mis_q) mis_cnt_q <= mis_cnt_q + 1'b1;
`endif
                        if (idx == N_IN'(DEPTH - 1)) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= DONE;
`ifdef SWEEP_CMP_EN
                            mis_q   <= 1'b0;
`endif
                        end else begin
                            idx   <= idx_nxt;
                            bit_q <= tt_q[idx_nxt];
`ifdef SWEEP_CMP_EN
                            mis_q <= tt_q[idx_nxt] ^ exp_q[idx_nxt];
`endif
                        end
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = valid_q;
    assign bus.out_vec   = idx;
    assign bus.out_bit   = bit_q;
    assign bus.ones_cnt  = ones_q;
    assign bus.done      = done_q;
`ifdef SWEEP_CMP_EN
    assign bus.mismatch     = mis_q;
    assign bus.mismatch_cnt = mis_cnt_q;
`endif
endmodule

// File: tb/tb_truth_table_sweep.sv
// tb_truth_table_sweep -- self-checking bench for truth_table_sweep with
// N_IN = 3 (directed and random sweeps), plus N_IN = 1 and N_IN = 6 random
// sweeps. Reference: row k of a sweep carries out_vec=k and out_bit=f(k);
// ones_cnt is the number of transferred rows with f=1.
// Build with SWEEP_CMP_EN defined to also check exp_tt/mismatch/mismatch_cnt.
module tb_truth_table_sweep;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    truth_table_sweep_if #(.N_IN(3)) b3 ();
    truth_table_sweep_if #(.N_IN(1)) b1 ();
    truth_table_sweep_if #(.N_IN(6)) b6 ();

    truth_table_sweep #(.N_IN(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
    truth_table_sweep #(.N_IN(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    truth_table_sweep #(.N_IN(6)) u6 (.clk(clk), .rst_n(rst_n), .bus(b6));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, b3.busy, 0);
        check({tag, "_valid"}, b3.out_valid, 0);
        check({tag, "_vec"}, b3.out_vec, 0);
        check({tag, "_bit"}, b3.out_bit, 0);
        check({tag, "_ones"}, b3.ones_cnt, 0);
        check({tag, "_done"}, b3.done, 0);
`ifdef SWEEP_CMP_EN
        check({tag, "_mis"}, b3.mismatch, 0);
        check({tag, "_miscnt"}, b3.mismatch_cnt, 0);
`endif
    endtask

    // rmode: 0 ready always 1, 1 ready toggles 1,0, 2 random ready.
    // abort_at / reset_at: row index at which to abort / reset (-1 none).
    // poke: stray start pulses and func_tt changes while busy.
    task automatic sweep3(input logic [7:0] tt, input logic [7:0] et, input int rmode,
                          input int abort_at, input int reset_at, input bit poke);
        int k = 0, ones = 0, mis = 0, c0;
        bit fin = 1'b0;
        bit rdy;
        @(negedge clk);
        b3.start = 1'b1;
        b3.func_tt = tt;
`ifdef SWEEP_CMP_EN
        b3.exp_tt = et;
`endif
        c0 = cyc;
        @(negedge clk);
        b3.start = 1'b0;
        for (int n = 0; n < 200 && !fin; n++) begin
            if (b3.done) begin
                check("done_busy", b3.busy, 1);
                check("done_valid", b3.out_valid, 0);
                check("done_ones", b3.ones_cnt, ones);
                check("done_rows", k, 8);
                if (rmode == 0) check("done_span", cyc - c0 + 1, 10);
`ifdef SWEEP_CMP_EN
                check("done_miscnt", b3.mismatch_cnt, mis);
`endif
                b3.start = poke;
                @(negedge clk);
                b3.start = 1'b0;
                check("after_done_busy", b3.busy, 0);
                check("after_done_pulse", b3.done, 0);
                check("after_done_ones", b3.ones_cnt, ones);
                fin = 1'b1;
            end else begin
                check("run_busy", b3.busy, 1);
                check("run_valid", b3.out_valid, 1);
                check("run_vec", b3.out_vec, k);
                check("run_bit", b3.out_bit, tt[k]);
                check("run_ones", b3.ones_cnt, ones);
`ifdef SWEEP_CMP_EN
                check("run_mis", b3.mismatch, tt[k] ^ et[k]);
                check("run_miscnt", b3.mismatch_cnt, mis);
`endif
                if (k == reset_at) begin
                    rst_n = 1'b0;
                    #1;
                    check_all_zero("rst_mid");
                    @(negedge clk);
                    rst_n = 1'b1;
                    fin = 1'b1;
                end else begin
                    rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? (n % 2 == 0) : 1'($urandom % 2);
                    b3.out_ready = rdy;
                    if (poke && ($urandom % 3 == 0)) begin
                        b3.start = 1'b1;
                        b3.func_tt = 8'($urandom);
                    end else begin
                        b3.start = 1'b0;
                    end
                    if (rdy && k == abort_at) begin
                        b3.abort = 1'b1;
                        @(negedge clk);
                        b3.abort = 1'b0;
                        b3.start = 1'b0;
                        check("abort_busy", b3.busy, 0);
                        check("abort_valid", b3.out_valid, 0);
                        for (int h = 0; h < 3; h++) begin
                            check("abort_no_done", b3.done, 0);
                            check("abort_ones_hold", b3.ones_cnt, ones);
`ifdef SWEEP_CMP_EN
                            check("abort_miscnt_hold", b3.mismatch_cnt, mis);
`endif
                            @(negedge clk);
                        end
                        fin = 1'b1;
                    end else begin
                        if (rdy) begin
                            ones += int'(tt[k]);
                            mis  += int'(tt[k] ^ et[k]);
                            k++;
                        end
                        @(negedge clk);
                    end
                end
            end
        end
        if (!fin) check("sweep3_timeout", 0, 1);
        b3.start = 1'b0;
        b3.abort = 1'b0;
        b3.out_ready = 1'b1;
    endtask

    task automatic sweep1(input logic [1:0] tt);
        int k = 0;
        bit fin = 1'b0;
        bit rdy;
        @(negedge clk);
        b1.start = 1'b1;
        b1.func_tt = tt;
        @(negedge clk);
        b1.start = 1'b0;
        for (int n = 0; n < 100 && !fin; n++) begin
            if (b1.done) begin
                check("n1_ones", b1.ones_cnt, $countones(tt));
                fin = 1'b1;
            end else begin
                rdy = 1'($urandom % 2);
                b1.out_ready = rdy;
                if (rdy) begin
                    check("n1_vec", b1.out_vec, k);
                    check("n1_bit", b1.out_bit, tt[k]);
                    k++;
                end
            end
            @(negedge clk);
        end
        if (!fin) check("n1_timeout", 0, 1);
    endtask

    task automatic sweep6(input logic [63:0] tt);
        int k = 0;
        bit fin = 1'b0;
        bit rdy;
        @(negedge clk);
        b6.start = 1'b1;
        b6.func_tt = tt;
        @(negedge clk);
        b6.start = 1'b0;
        for (int n = 0; n < 1000 && !fin; n++) begin
            if (b6.done) begin
                check("n6_ones", b6.ones_cnt, $countones(tt));
                fin = 1'b1;
            end else begin
                rdy = 1'($urandom % 2);
                b6.out_ready = rdy;
                if (rdy) begin
                    check("n6_vec", b6.out_vec, k);
                    check("n6_bit", b6.out_bit, tt[k]);
                    k++;
                end
            end
            @(negedge clk);
        end
        if (!fin) check("n6_timeout", 0, 1);
    endtask

    initial begin
        logic [7:0] held;
        rst_n = 1'b0;
        b3.start = 1'b0; b3.abort = 1'b0; b3.func_tt = '0; b3.out_ready = 1'b1;
        b1.start = 1'b0; b1.abort = 1'b0; b1.func_tt = '0; b1.out_ready = 1'b1;
        b6.start = 1'b0; b6.abort = 1'b0; b6.func_tt = '0; b6.out_ready = 1'b1;
`ifdef SWEEP_CMP_EN
        b3.exp_tt = '0; b1.exp_tt = '0; b6.exp_tt = '0;
`endif
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        sweep3(8'hB4, 8'hB5, 0, -1, -1, 1'b0);
        sweep3(8'hB4, 8'hB5, 1, -1, -1, 1'b0);
        sweep3(8'hFF, 8'hFF, 0, 2, -1, 1'b0);

        // Abort while idle must not disturb anything.
        held = 8'(b3.ones_cnt);
        b3.abort = 1'b1;
        @(negedge clk);
        b3.abort = 1'b0;
        check("idle_abort_busy", b3.busy, 0);
        check("idle_abort_ones", b3.ones_cnt, held);

        sweep3(8'h0F, 8'h0F, 0, -1, 4, 1'b0);
        sweep3(8'h01, 8'h00, 0, -1, -1, 1'b0);
        sweep3(8'hB4, 8'($urandom), 0, -1, -1, 1'b1);
        for (int i = 0; i < 8; i++)
            sweep3(8'($urandom), 8'($urandom), 2, int'($urandom % 12), -1, 1'($urandom % 2));

        for (int i = 0; i < 4; i++) sweep1(2'($urandom));
        for (int i = 0; i < 3; i++) sweep6({$urandom, $urandom});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/truth_table_sweep.md
TRUTH_TABLE_SWEEP -- requirements
Module: truth_table_sweep

Interface
REQ-001 The module SHALL have parameter N_IN, default 3, the number of Boolean inputs swept (legal 1..6).
REQ-002 The module SHALL have localparam DEPTH = 2**N_IN, the number of truth-table rows.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a sweep; sampled only in IDLE.
REQ-006 abort  input  1  terminate a running sweep; sampled only in RUN.
REQ-007 func_tt  input  DEPTH  function under evaluation; bit i is f(i); captured on accepted start.
REQ-008 out_ready  input  1  downstream ready for the current row.
REQ-009 busy  output  1  high in RUN and DONE.
REQ-010 out_valid  output  1  current row is presented.
REQ-011 out_vec  output  N_IN  input combination of the current row.
REQ-012 out_bit  output  1  captured f(out_vec).
REQ-013 ones_cnt  output  N_IN+1  count of rows with out_bit=1 transferred in the current or last sweep.
REQ-014 done  output  1  one-cycle pulse on sweep completion.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-016 In IDLE with start=1, the next edge SHALL capture func_tt into tt_q, clear idx and ones_cnt (plus mismatch_cnt when REQ-030 applies), and enter RUN.
REQ-017 In RUN, out_valid SHALL be 1, out_vec SHALL equal idx, and out_bit SHALL equal tt_q[idx], all driven from registers.
REQ-018 A transfer SHALL occur on any edge where out_valid=1 and out_ready=1; ones_cnt SHALL increment by out_bit on that edge.
REQ-019 On a transfer with idx < DEPTH-1, idx SHALL increment by 1; with idx = DEPTH-1, the FSM SHALL enter DONE and idx SHALL NOT wrap.
REQ-020 While out_ready=0 in RUN, out_vec, out_bit and all counters SHALL hold their values.
REQ-021 In DONE, done SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-022 start in RUN or DONE SHALL be ignored; changes to func_tt after capture SHALL have no effect until the next accepted start.
REQ-023 abort=1 in RUN SHALL return the FSM to IDLE at the next edge without a done pulse; a transfer on that same edge SHALL NOT be counted.
REQ-024 abort in IDLE or DONE SHALL be ignored.
REQ-025 ones_cnt (and mismatch_cnt when REQ-030 applies) SHALL hold their final or aborted values in IDLE until the next accepted start.
REQ-026 Minimum sweep time SHALL be DEPTH+2 cycles from start to done with out_ready held at 1.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, idx=0, tt_q=0, busy=0, out_valid=0, out_vec=0, out_bit=0, ones_cnt=0 and done=0, independent of clk, including mid-sweep.
REQ-028 After rst_n deasserts, the first accepted start SHALL be no earlier than the first rising edge following deassertion.

Configuration
REQ-029 Macro SWEEP_CMP_EN SHALL control the compare feature.
REQ-030 With SWEEP_CMP_EN defined, the module SHALL add the following ports and behaviour:
- input exp_tt (width DEPTH), captured with func_tt;
- output mismatch (1 bit), equal to out_bit XOR exp_q[idx] and qualified by out_valid;
- output mismatch_cnt (width N_IN+1), incremented on each transfer where mismatch=1.
REQ-031 Without SWEEP_CMP_EN, these ports and the registers behind them SHALL NOT exist, and all other behaviour SHALL be unchanged.

Verification
REQ-032 N_IN=3, func_tt=8'hB4, out_ready=1, start pulse:
- rows 0..7 stream out_bit 0,0,1,0,1,1,0,1 on consecutive cycles;
- ones_cnt=4 at the done pulse;
- done occurs 10 cycles after start.
REQ-033 Same stimulus as REQ-032 with out_ready toggling 1,0 every cycle: the same bit sequence appears, each row is held 2 cycles, and ones_cnt=4.
REQ-034 Sweep with func_tt=8'hFF, with abort asserted on the edge of the 3rd transfer:
- the FSM returns to IDLE;
- done never pulses;
- ones_cnt=2 and holds.
REQ-035 With func_tt=8'h0F, rst_n dropped at row 4 while clk is low: all outputs are 0 immediately; a new start with func_tt=8'h01 gives ones_cnt=1.
REQ-036 start re-asserted during RUN and in the DONE cycle is ignored; func_tt changed mid-sweep does not alter the out_bit stream.
REQ-037 With SWEEP_CMP_EN defined: func_tt=8'hB4 and exp_tt=8'hB5 gives mismatch=1 only at row 0 and mismatch_cnt=1; N_IN=1 and N_IN=6 each complete with ones_cnt equal to popcount(func_tt).
